phase2_driver: RTL
==================

PHASE2_DRIVER -- requirements
Module: phase2_driver

Interface
REQ-001 SHALL have parameter HOLD_TIMEOUT, default 16: maximum DRIVE cycles allowed before phase2_done is seen.
REQ-002 SHALL have parameter FAIL_GRACE, default 2: DRIVE cycles during which phase2_fail is ignored, covering checker register latency.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request to present a code; sampled only in IDLE.
REQ-006 SHALL have port code_in, input, 4: code to present; captured on the accepted start.
REQ-007 SHALL have port phase2_done, input, 1: checker success indication.
REQ-008 SHALL have port phase2_fail, input, 1: checker mismatch indication.
REQ-009 SHALL have port switch_out, output, 4: registered switch pattern driven to the checker.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port pass, output, 1: one-cycle pulse when the checker accepts the code.
REQ-012 SHALL have port fail, output, 1: one-cycle pulse when the attempt is abandoned.

Function
REQ-013 SHALL implement the states IDLE, DRIVE, GAP, PASS and FAIL; all outputs SHALL be registered.
REQ-014 IDLE: switch_out = 4'b0000; when start=1, code_in SHALL be latched, the cycle counter cleared, and the next state SHALL be DRIVE.
REQ-015 DRIVE: switch_out SHALL equal the latched code from the first DRIVE cycle onward, and the 5-bit cycle counter SHALL increment once per cycle.
REQ-016 DRIVE: phase2_done=1 SHALL move the block to PASS; done SHALL take priority over fail and over timeout in the same cycle.
REQ-017 DRIVE: phase2_fail=1 while counter >= FAIL_GRACE SHALL count as an attempt failure; phase2_fail SHALL be ignored while counter < FAIL_GRACE.
REQ-018 DRIVE: counter == HOLD_TIMEOUT-1 without phase2_done SHALL count as an attempt failure (timeout).
REQ-019 An attempt failure SHALL move the block to FAIL, except as stated in REQ-026.
REQ-020 PASS SHALL assert pass for exactly one cycle with switch_out = 0, then return to IDLE.
REQ-021 FAIL SHALL assert fail for exactly one cycle with switch_out = 0, then return to IDLE.
REQ-022 start SHALL be ignored while busy=1; it is never queued.
REQ-023 Changes on code_in after capture SHALL NOT affect switch_out.
REQ-024 pass and fail SHALL never be asserted in the same cycle.

Reset
REQ-025 When reset=1, at any time including mid-DRIVE, the block SHALL immediately enter IDLE with switch_out=0, busy=0, pass=0, fail=0, the counter cleared and the retry count cleared.

Configuration
REQ-026 With macro PHASE2_DRIVER_RETRY_EN defined:
- An attempt failure with retry count < 3 SHALL increment the retry count and move the block to GAP.
- GAP SHALL drive switch_out = 0 for exactly 2 cycles (to clear the checker's hold count), then re-enter DRIVE with the counter cleared.
- The fourth attempt failure SHALL move the block to FAIL.
REQ-027 Without PHASE2_DRIVER_RETRY_EN, GAP and the retry counter SHALL NOT exist, and every attempt failure SHALL move the block directly to FAIL.

Structure
REQ-028 Package vault_pkg SHALL hold:
- the state enum type;
- CODE_W = 4;
- RETRY_MAX = 3;
- GAP_CYCLES = 2.
REQ-029 The block SHALL be a single module with no sub-modules; the counter is inline.

Verification
REQ-030 Paired with the phase2 checker, start with code_in=4'b1101 -> pass pulses once on the cycle after phase2_done first rises (about 7 cycles after start); fail stays 0.
REQ-031 Start with code_in=4'b1001 and retry disabled -> fail pulses once FAIL_GRACE cycles into DRIVE; switch_out returns to 0.
REQ-032 Stub checker holds done=0 and fail=0 -> fail pulses after exactly 16 DRIVE cycles.
REQ-033 Retry enabled, wrong code -> four DRIVE phases separated by 2-cycle GAPs of switch_out=0, then one fail pulse.
REQ-034 Assert reset on DRIVE cycle 3 -> switch_out=0 and busy=0 immediately; a later start begins a fresh attempt.
REQ-035 Pulse start again on DRIVE cycle 1 with code_in=4'b0000 -> ignored; switch_out remains the original code.

Source files
------------

// File: rtl/vault_pkg.sv
// Shared types and constants for the vault phase-2 driver.
// The GAP state exists only when PHASE2_DRIVER_RETRY_EN is defined.
package vault_pkg;

  localparam int unsigned CODE_W     = 4;
  localparam int unsigned RETRY_MAX  = 3;
  localparam int unsigned GAP_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
`ifdef PHASE2_DRIVER_RETRY_EN
    ST_GAP   = 3'd2,
`endif
    ST_PASS  = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

endpackage

// File: rtl/phase2_driver.sv
// Presents a captured code to the phase-2 checker and reports pass/fail.
// Optional retry with switch-clearing gaps: define PHASE2_DRIVER_RETRY_EN.
module phase2_driver
  import vault_pkg::*;
#(
  parameter int HOLD_TIMEOUT = 16,
  parameter int FAIL_GRACE   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CODE_W-1:0] code_in,
  input  logic              phase2_done,
  input  logic              phase2_fail,
  output logic [CODE_W-1:0] switch_out,
  output logic              busy,
  output logic              pass,
  output logic              fail
);

  localparam logic [4:0] TIMEOUT_CNT = 5'(HOLD_TIMEOUT - 1);
  localparam logic [4:0] GRACE_CNT   = 5'(FAIL_GRACE);

  state_t              state_r;
  state_t              next_state_s;
  logic [4:0]          cnt_r;
  logic [4:0]          cnt_next_s;
  logic [CODE_W-1:0]   code_r;
  logic [CODE_W-1:0]   code_next_s;
  logic [CODE_W-1:0]   switch_r;
  logic [CODE_W-1:0]   switch_next_s;
  logic                busy_r;
  logic                busy_next_s;
  logic                pass_r;
  logic                pass_next_s;
  logic                fail_r;
  logic                fail_next_s;
  logic                attempt_fail_s;

`ifdef PHASE2_DRIVER_RETRY_EN
  localparam logic [4:0] GAP_LAST  = 5'(GAP_CYCLES - 1);
  localparam logic [1:0] RETRY_LIM = 2'(RETRY_MAX);
  logic [1:0]          retry_r;
  logic [1:0]          retry_next_s;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 5'd0;
      code_r   <= {CODE_W{1'b0}};
      switch_r <= {CODE_W{1'b0}};
      busy_r   <= 1'b0;
      pass_r   <= 1'b0;
      fail_r   <= 1'b0;
`ifdef PHASE2_DRIVER_RETRY_EN
      retry_r  <= 2'd0;
`endif
    end else begin
      state_r  <= next_state_s;
      cnt_r    <= cnt_next_s;
      code_r   <= code_next_s;
      switch_r <= switch_next_s;
      busy_r   <= busy_next_s;
      pass_r   <= pass_next_s;
      fail_r   <= fail_next_s;
`ifdef PHASE2_DRIVER_RETRY_EN
      retry_r  <= retry_next_s;
`endif
    end
  end

  // Next-state decode; done outranks both fail and timeout
  always_comb begin
    next_state_s   = state_r;
    attempt_fail_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) next_state_s = ST_DRIVE;
        else       next_state_s = ST_IDLE;
      end
      ST_DRIVE: begin
        if (phase2_done) begin
          next_state_s = ST_PASS;
        end else if ((phase2_fail && (cnt_r >= GRACE_CNT)) || (cnt_r == TIMEOUT_CNT)) begin
          attempt_fail_s = 1'b1;
`ifdef PHASE2_DRIVER_RETRY_EN
          if (retry_r < RETRY_LIM) next_state_s = ST_GAP;
          else                     next_state_s = ST_FAIL;
`else
          next_state_s = ST_FAIL;
`endif
        end else begin
          next_state_s = ST_DRIVE;
        end
      end
`ifdef PHASE2_DRIVER_RETRY_EN
      ST_GAP: begin
        if (cnt_r == GAP_LAST) next_state_s = ST_DRIVE;
        else                   next_state_s = ST_GAP;
      end
`endif
      ST_PASS: next_state_s = ST_IDLE;
      ST_FAIL: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Next register values; outputs are decoded from the next state so they are registered
  always_comb begin
    cnt_next_s    = 5'd0;
    code_next_s   = code_r;
    switch_next_s = {CODE_W{1'b0}};
    if ((next_state_s == state_r) && (state_r != ST_IDLE)) cnt_next_s = cnt_r + 5'd1;
    else                                                  cnt_next_s = 5'd0;
    if ((state_r == ST_IDLE) && start) code_next_s = code_in;
    else                               code_next_s = code_r;
    if (next_state_s == ST_DRIVE) switch_next_s = code_next_s;
    else                          switch_next_s = {CODE_W{1'b0}};
    busy_next_s = (next_state_s != ST_IDLE);
    pass_next_s = (next_state_s == ST_PASS);
    fail_next_s = (next_state_s == ST_FAIL);
  end

`ifdef PHASE2_DRIVER_RETRY_EN
  // Retry count: cleared in IDLE, bumped on each retried failure
  always_comb begin
    retry_next_s = retry_r;
    if (state_r == ST_IDLE)                       retry_next_s = 2'd0;
    else if (attempt_fail_s && (next_state_s == ST_GAP)) retry_next_s = retry_r + 2'd1;
    else                                          retry_next_s = retry_r;
  end
`endif

  assign switch_out = switch_r;
  assign busy       = busy_r;
  assign pass       = pass_r;
  assign fail       = fail_r;

endmodule
